// File: rtl/key_device.sv
// Four push-button debouncer with memory-mapped KDATA/KCTRL registers and a level interrupt.
// Each key is synchronized, inverted to active-high and accepted after a persistent change.
module key_device #(
   parameter int unsigned      DBITS           = 32,
   parameter logic [DBITS-1:0] ADDR_KDATA      = 32'hF0000010,
   parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
   parameter logic [15:0]      DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       key_in,
   input  logic [DBITS-1:0] addr,
   input  logic             wrEn,
   input  logic             rdEn,
   input  logic [DBITS-1:0] dataIn,
   output logic [DBITS-1:0] dataOut,
   output logic             sel,
   output logic             intr
);

   localparam logic [15:0] CntMax = DEBOUNCE_CYCLES - 16'd1;

   logic [3:0]       syncA, syncB, sample;
   logic [3:0]       stableQ, stableD, update;
   logic [3:0][15:0] cntQ, cntD;
   logic             rdyQ, rdyD, ovrQ, ovrD, ieQ, ieD, intrQ;
   logic             isKdata, isKctrl, kdataRd, kctrlWr, change;
   logic             unusedDataIn;

   assign isKdata = (addr == ADDR_KDATA);
   assign isKctrl = (addr == ADDR_KCTRL);
   assign sel     = isKdata | isKctrl;
   assign kdataRd = isKdata & rdEn;
   assign kctrlWr = isKctrl & wrEn;

   // Synchronizer flops idle at 1 (button released) so reset never looks like a press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         syncA <= 4'hF;
         syncB <= 4'hF;
      end else begin
         syncA <= key_in;
         syncB <= syncA;
      end
   end

   assign sample = ~syncB;

   always_comb begin
      cntD    = cntQ;
      stableD = stableQ;
      update  = 4'b0;
      for (int k = 0; k < 4; k++) begin
         if (sample[k] == stableQ[k]) begin
            cntD[k] = 16'd0;
         end else if (cntQ[k] == CntMax) begin
            stableD[k] = sample[k];
            cntD[k]    = 16'd0;
            update[k]  = 1'b1;
         end else begin
            cntD[k] = cntQ[k] + 16'd1;
         end
      end
   end

   assign change = |update;

   // A change event takes priority over the read/write that would clear the same flag.
   always_comb begin
      rdyD = rdyQ;
      if (change) begin
         rdyD = 1'b1;
      end else if (kdataRd) begin
         rdyD = 1'b0;
      end

      ovrD = ovrQ;
      if (change && rdyQ && !kdataRd) begin
         ovrD = 1'b1;
      end else if (kctrlWr && !dataIn[1]) begin
         ovrD = 1'b0;
      end

      ieD = kctrlWr ? dataIn[4] : ieQ;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stableQ <= 4'b0;
         cntQ    <= '0;
         rdyQ    <= 1'b0;
         ovrQ    <= 1'b0;
         ieQ     <= 1'b0;
         intrQ   <= 1'b0;
      end else begin
         stableQ <= stableD;
         cntQ    <= cntD;
         rdyQ    <= rdyD;
         ovrQ    <= ovrD;
         ieQ     <= ieD;
         intrQ   <= rdyD & ieD;
      end
   end

   assign intr = intrQ;

   always_comb begin
      dataOut = '0;
      if (isKdata) begin
         dataOut[3:0] = stableQ;
      end else if (isKctrl) begin
         dataOut[4] = ieQ;
         dataOut[1] = ovrQ;
         dataOut[0] = rdyQ;
      end
   end

   // Only IE and the OVR-clear bit of a store carry meaning.
   assign unusedDataIn = ^{dataIn[DBITS-1:5], dataIn[3:2], dataIn[0]};

endmodule

// File: tb/tb_key_device.sv
// Randomized bench for key_device against a history-window reference model,
// plus directed scenarios with constant expectations (DEBOUNCE_CYCLES = 4).
module tb_key_device;

   localparam int          D     = 4;
   localparam logic [31:0] KDATA = 32'hF0000010;
   localparam logic [31:0] KCTRL = 32'hF0000110;
   localparam logic [31:0] OTHER = 32'hF0000014;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  key_in = 4'hF;
   logic [31:0] addr = 32'h0;
   logic        wrEn = 1'b0;
   logic        rdEn = 1'b0;
   logic [31:0] dataIn = 32'h0;
   logic [31:0] dataOut;
   logic        sel;
   logic        intr;

   int nVec = 0;
   int nMis = 0;

   // Reference model state
   logic [3:0] mRaw1, mRaw2;   // raw key_in seen one and two edges ago
   logic [3:0] smpQ[$];        // last D active-high samples seen by the debouncer
   logic [3:0] mStable;
   logic       mRdy, mOvr, mIe, mIntr;

   key_device #(
      .DBITS(32),
      .ADDR_KDATA(KDATA),
      .ADDR_KCTRL(KCTRL),
      .DEBOUNCE_CYCLES(16'd4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .key_in(key_in),
      .addr(addr),
      .wrEn(wrEn),
      .rdEn(rdEn),
      .dataIn(dataIn),
      .dataOut(dataOut),
      .sel(sel),
      .intr(intr)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nMis++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] expDout(input logic [31:0] a);
      if (a == KDATA) return {28'b0, mStable};
      if (a == KCTRL) return {27'b0, mIe, 2'b0, mOvr, mRdy};
      return 32'h0;
   endfunction

   task automatic modelReset();
      mRaw1 = 4'hF;
      mRaw2 = 4'hF;
      smpQ.delete();
      mStable = 4'b0;
      mRdy = 1'b0;
      mOvr = 1'b0;
      mIe = 1'b0;
      mIntr = 1'b0;
   endtask

   // A key is accepted once its last D samples all disagree with the accepted level.
   task automatic modelEdge();
      logic [3:0] upd;
      logic       chg, kRd, kWr, nRdy, nOvr, nIe, allDiff;
      smpQ.push_back(~mRaw2);
      if (smpQ.size() > D) void'(smpQ.pop_front());
      upd = 4'b0;
      if (smpQ.size() == D) begin
         for (int k = 0; k < 4; k++) begin
            allDiff = 1'b1;
            for (int i = 0; i < D; i++) if (smpQ[i][k] == mStable[k]) allDiff = 1'b0;
            upd[k] = allDiff;
         end
      end
      chg = |upd;
      kRd = (addr == KDATA) && rdEn;
      kWr = (addr == KCTRL) && wrEn;
      nRdy = chg ? 1'b1 : (kRd ? 1'b0 : mRdy);
      nOvr = (chg && mRdy && !kRd) ? 1'b1 : ((kWr && !dataIn[1]) ? 1'b0 : mOvr);
      nIe = kWr ? dataIn[4] : mIe;
      mStable = mStable ^ upd;
      mRdy = nRdy;
      mOvr = nOvr;
      mIe = nIe;
      mIntr = nRdy & nIe;
      mRaw2 = mRaw1;
      mRaw1 = key_in;
   endtask

   // Called at a negedge; applies one cycle of stimulus and returns at the next negedge.
   task automatic drive(input logic [3:0] k, input logic [31:0] a, input logic r, input logic w,
                        input logic [31:0] d);
      key_in = k;
      addr = a;
      rdEn = r;
      wrEn = w;
      dataIn = d;
      #1;
      checkVal("sel", {31'b0, sel}, {31'b0, (a == KDATA) || (a == KCTRL)});
      checkVal("dataOut", dataOut, expDout(a));
      @(posedge clk);
      #1;
      modelEdge();
      checkVal("intr", {31'b0, intr}, {31'b0, mIntr});
      @(negedge clk);
   endtask

   task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      rdEn = 1'b0;
      wrEn = 1'b0;
      #1;
      checkVal(tag, dataOut, exp);
   endtask

   task automatic applyReset();
      reset = 1'b0;
      #1;
      modelReset();
      checkVal("rst_intr", {31'b0, intr}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      int hold;
      logic [3:0] kpat;
      logic [31:0] a;
      modelReset();
      @(negedge clk);
      applyReset();
      peek("rst_kdata", KDATA, 32'h0);
      peek("rst_kctrl", KCTRL, 32'h0);

      // Key0 held: accepted on exactly the sixth edge.
      for (int i = 0; i < 5; i++) drive(4'b1110, KDATA, 1'b0, 1'b0, 32'h0);
      peek("s1_pre", KDATA, 32'h0);
      drive(4'b1110, KDATA, 1'b0, 1'b0, 32'h0);
      peek("s1_kdata", KDATA, 32'h1);
      peek("s1_kctrl", KCTRL, 32'h1);
      drive(4'b1110, KDATA, 1'b1, 1'b0, 32'h0);
      peek("s1_rdclr", KCTRL, 32'h0);

      // Bouncing key0 never settles.
      applyReset();
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 3; i++) drive(4'b1110, OTHER, 1'b0, 1'b0, 32'h0);
         drive(4'b1111, OTHER, 1'b0, 1'b0, 32'h0);
      end
      for (int i = 0; i < 4; i++) drive(4'b1111, OTHER, 1'b0, 1'b0, 32'h0);
      peek("s2_kdata", KDATA, 32'h0);
      peek("s2_kctrl", KCTRL, 32'h0);

      // Interrupt enabled, key1 pressed.
      applyReset();
      drive(4'b1111, KCTRL, 1'b0, 1'b1, 32'h10);
      for (int i = 0; i < 5; i++) drive(4'b1101, OTHER, 1'b0, 1'b0, 32'h0);
      checkVal("s3_intr_pre", {31'b0, intr}, 32'h0);
      drive(4'b1101, OTHER, 1'b0, 1'b0, 32'h0);
      checkVal("s3_intr_set", {31'b0, intr}, 32'h1);
      drive(4'b1101, KDATA, 1'b1, 1'b0, 32'h0);
      checkVal("s3_intr_clr", {31'b0, intr}, 32'h0);
      peek("s3_kctrl", KCTRL, 32'h10);

      // Press and release key2 without a read -> overrun; clear it with a write of 0.
      applyReset();
      for (int i = 0; i < 6; i++) drive(4'b1011, OTHER, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 6; i++) drive(4'b1111, OTHER, 1'b0, 1'b0, 32'h0);
      peek("s4_ovr", KCTRL, 32'h3);
      drive(4'b1111, KCTRL, 1'b0, 1'b1, 32'h0);
      peek("s4_clr", KCTRL, 32'h1);

      // Change event coincident with a KDATA read.
      applyReset();
      for (int i = 0; i < 5; i++) drive(4'b0111, OTHER, 1'b0, 1'b0, 32'h0);
      drive(4'b0111, KDATA, 1'b1, 1'b0, 32'h0);
      peek("s5_coinc", KCTRL, 32'h1);
      peek("s5_kdata", KDATA, 32'h8);
      // Asynchronous reset in the middle of a key0 debounce.
      for (int i = 0; i < 3; i++) drive(4'b0110, OTHER, 1'b0, 1'b0, 32'h0);
      #2;
      reset = 1'b0;
      #1;
      modelReset();
      checkVal("s5_rst_intr", {31'b0, intr}, 32'h0);
      peek("s5_rst_kdata", KDATA, 32'h0);
      peek("s5_rst_kctrl", KCTRL, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) drive(4'b1110, OTHER, 1'b0, 1'b0, 32'h0);
      peek("s5_restart_pre", KDATA, 32'h0);
      drive(4'b1110, OTHER, 1'b0, 1'b0, 32'h0);
      peek("s5_restart", KDATA, 32'h1);

      // Neighbouring address decodes to nothing; KDATA is read-only.
      peek("s6_other", OTHER, 32'h0);
      checkVal("s6_sel", {31'b0, sel}, 32'h0);
      drive(4'b1110, KDATA, 1'b0, 1'b1, 32'hFFFF_FFFF);
      peek("s6_ro", KDATA, 32'h1);

      // Randomized traffic against the model.
      applyReset();
      kpat = 4'hF;
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
         if (hold == 0) begin
            kpat = 4'($urandom);
            hold = $urandom_range(1, 10);
         end
         hold--;
         case ($urandom_range(0, 3))
            0: a = KDATA;
            1: a = KCTRL;
            2: a = OTHER;
            default: a = $urandom;
         endcase
         drive(kpat, a, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
